serial_rx_fifo: RTL and testbench



---
 rtl/serial_rx_fifo.sv | 122 ++++++++++++
 tb/tb_serial_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: receive byte buffer that sits behind serial_rx.
// Each i_wr/i_data strobe is stored in a circular FIFO. The consumer sees the
// head byte first-word-fall-through on o_valid/o_data and pops it with i_rd.
// The block also reports occupancy, full, and a sticky overrun flag.
// Optional feature: define SERIAL_RX_FIFO_ALMOST_FULL_EN to add a registered
// o_almost_full output that is set when count >= AF_LEVEL.
module serial_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
  , parameter int AF_LEVEL = 12
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  input  logic                  i_rd,
  input  logic                  i_clr,
  output logic                  o_valid,
  output logic [7:0]            o_data,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overrun
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
  , output logic                o_almost_full
`endif
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2-1:0] rptr_nxt;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            data_q, data_d;
  logic                  overrun_q, overrun_d;
  logic                  empty, full;
  logic                  rd_acc, wr_acc, drop;

  // Handshake decode: a read is honoured only while non-empty. A write is
  // accepted when there is room, or when a read frees a slot in the same cycle.
  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == FULL_CNT);
    rd_acc = i_rd & ~empty;
    wr_acc = i_wr & (~full | rd_acc);
    drop   = i_wr & ~wr_acc;
  end

  // Next-state for pointers, occupancy, head register, and overrun flag.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rptr_nxt  = rptr_q + 1'b1;
    count_d   = count_q;
    data_d    = data_q;
    overrun_d = drop | (overrun_q & ~i_clr);

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_nxt;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // When popping the last stored byte while a new one arrives, the new
    // byte becomes the head before it has reached memory, so it is bypassed.
    if (rd_acc) begin
      if (wr_acc && (count_q == ONE_CNT)) data_d = i_data;
      else                                data_d = mem_q[rptr_nxt];
    end else if (wr_acc && empty) begin
      data_d = i_data;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wptr_q] <= i_data;
  end

  // Control and head-output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
  localparam logic [DEPTH_LOG2:0] AF_CNT = (DEPTH_LOG2 + 1)'(AF_LEVEL);
  logic af_q;

  // Flow-control hint: tracks the post-edge occupancy against the threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) af_q <= 1'b0;
    else          af_q <= (count_d >= AF_CNT);
  end

  assign o_almost_full = af_q;
`endif

  assign o_valid   = ~empty;
  assign o_full    = full;
  assign o_count   = count_q;
  assign o_data    = data_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Self-checking bench for serial_rx_fifo. The reference model is a byte queue
// plus an overrun bit; the bench compares it against the DUT after every edge.
module tb_serial_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int AF    = 12;

  logic           clk;
  logic           rst_n;
  logic           wr;
  logic [7:0]     din;
  logic           rd;
  logic           clr;
  logic           o_valid;
  logic [7:0]     o_data;
  logic           o_full;
  logic [DL2:0]   o_count;
  logic           o_overrun;
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
  logic           o_almost_full;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] mq[$];
  logic       m_ovr;

  serial_rx_fifo #(
    .DEPTH_LOG2(DL2)
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
    , .AF_LEVEL(AF)
`endif
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr      (wr),
    .i_data    (din),
    .i_rd      (rd),
    .i_clr     (clr),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_full    (o_full),
    .o_count   (o_count),
    .o_overrun (o_overrun)
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
    , .o_almost_full(o_almost_full)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed=%0h required=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check_val("valid", {31'b0, o_valid}, {31'b0, mq.size() != 0});
    check_val("count", {27'b0, o_count}, mq.size());
    check_val("full", {31'b0, o_full}, {31'b0, mq.size() == DEPTH});
    check_val("overrun", {31'b0, o_overrun}, {31'b0, m_ovr});
    if (mq.size() != 0) check_val("head", {24'b0, o_data}, {24'b0, mq[0]});
`ifdef SERIAL_RX_FIFO_ALMOST_FULL_EN
    check_val("almost_full", {31'b0, o_almost_full}, {31'b0, mq.size() >= AF});
`endif
  endtask

  // Drive one cycle, apply the queue model for that edge, then compare.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    int  sz;
    bit  rd_ok;
    bit  dropped;
    wr = w; din = d; rd = r; clr = c;
    @(posedge clk);
    #1;
    sz      = mq.size();
    rd_ok   = r && (sz > 0);
    dropped = w && (sz == DEPTH) && !rd_ok;
    if (rd_ok) void'(mq.pop_front());
    if (w && !dropped) mq.push_back(d);
    m_ovr = dropped ? 1'b1 : (c ? 1'b0 : m_ovr);
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, {31'b0, o_valid}, 0);
    check_val({tag, "_count"}, {27'b0, o_count}, 0);
    check_val({tag, "_full"}, {31'b0, o_full}, 0);
    check_val({tag, "_overrun"}, {31'b0, o_overrun}, 0);
    check_val({tag, "_data"}, {24'b0, o_data}, 0);
  endtask

  initial begin
    int rd_pct;
    rst_n = 1'b0; wr = 1'b0; din = 8'h00; rd = 1'b0; clr = 1'b0;
    m_ovr = 1'b0;
    #12;
    check_reset_outputs("reset");
    #5 rst_n = 1'b1;

    // Single byte in, single byte out.
    step(1'b1, 8'h4B, 1'b0, 1'b0);
    check_val("k_data", {24'b0, o_data}, 32'h4B);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("k_empty", {31'b0, o_valid}, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);   // read while empty is ignored

    // Ordering across pointer wrap with interleaved reads.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), (i % 2) == 1, 1'b0);
    while (mq.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("wrap_overrun", {31'b0, o_overrun}, 0);

    // Fill, overrun, clear.
    for (int i = 0; i < 16; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check_val("fill_full", {31'b0, o_full}, 1);
    check_val("fill_count", {27'b0, o_count}, 16);
    check_val("fill_overrun", {31'b0, o_overrun}, 1);
    check_val("fill_head", {24'b0, o_data}, 32'hA0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);   // drop together with clear: set wins
    check_val("clr_vs_drop", {31'b0, o_overrun}, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("clr_overrun", {31'b0, o_overrun}, 0);

    // Full with simultaneous write and read.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check_val("fullrw_count", {27'b0, o_count}, 16);
    check_val("fullrw_overrun", {31'b0, o_overrun}, 0);
    check_val("fullrw_head", {24'b0, o_data}, 32'hA1);
    while (mq.size() > 1) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("fullrw_last", {24'b0, o_data}, 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with simultaneous write and read.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_val("emptyrw_count", {27'b0, o_count}, 1);
    check_val("emptyrw_data", {24'b0, o_data}, 32'h55);
    // One stored byte, read plus write: the new byte must fall through.
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check_val("onerw_data", {24'b0, o_data}, 32'h66);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with phases that bias toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      rd_pct = ((i / 150) % 2 == 0) ? 25 : 80;
      step($urandom_range(99) < 55, 8'($urandom), $urandom_range(99) < rd_pct,
           $urandom_range(99) < 4);
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check_val("post_reset_data", {24'b0, o_data}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
